// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: framer state encoding, frame geometry and CRC-32 polynomial.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam int          PREAMBLE_BITS   = 56;
  localparam logic [7:0]  SFD             = 8'hD5;
  localparam int          MIN_FRAME_BYTES = 60;
  localparam int          FCS_BITS        = 32;
  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;

endpackage

// File: rtl/eth_fcs.sv
// Bit-serial Ethernet CRC-32 register; one input bit per enabled cycle, sync preset to all ones.
module eth_fcs
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reset,
  input  logic        en,
  input  logic        data_in,
  output logic [31:0] crc
);

  logic fb;
  assign fb = crc[31] ^ data_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 32'hFFFF_FFFF;
    end else if (reset) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Serial Ethernet framer: preamble/SFD, LSB-first payload, optional zero pad, FCS, inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad frames shorter than 60 payload bytes.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int IFG_BITS = 96
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_en,
  output logic       frame_done,
  output logic       underrun
);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  shreg;
  logic        last_q;
  logic        accept;
  logic        crc_en;
  logic        crc_rst;
  logic [31:0] crc;
  logic [4:0]  fcs_idx;
  logic [7:0]  sfd_pat;

  assign accept  = in_ready && in_valid;
  assign crc_rst = (state == ST_IDLE) || (state == ST_PREAMBLE) || (state == ST_SFD);
  assign fcs_idx = 5'(FCS_BITS - 1) - cnt[4:0];
  assign sfd_pat = SFD;

`ifdef ETH_TX_PAD_EN
  logic [5:0] byte_cnt;

  // Payload bytes completed in this frame, saturating at the minimum frame size.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
    end else if (state == ST_PREAMBLE) begin
      byte_cnt <= '0;
    end else if ((state == ST_DATA || state == ST_PAD) && cnt == 8'd7 &&
                 byte_cnt != 6'(MIN_FRAME_BYTES)) begin
      byte_cnt <= byte_cnt + 6'd1;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 8'd1;
    tx_bit     = 1'b0;
    tx_en      = 1'b0;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    underrun   = 1'b0;
    crc_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (in_valid) state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        tx_en  = 1'b1;
        tx_bit = ~cnt[0];
        if (cnt == 8'(PREAMBLE_BITS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_SFD;
        end
      end
      ST_SFD: begin
        tx_en  = 1'b1;
        tx_bit = sfd_pat[cnt[2:0]];
        if (cnt == 8'd7) begin
          cnt_nxt   = '0;
          in_ready  = 1'b1;
          underrun  = ~in_valid;
          state_nxt = in_valid ? ST_DATA : ST_IFG;
        end
      end
      ST_DATA: begin
        tx_en  = 1'b1;
        tx_bit = shreg[0];
        crc_en = 1'b1;
        if (cnt == 8'd7) begin
          cnt_nxt = '0;
          if (!last_q) begin
            in_ready  = 1'b1;
            underrun  = ~in_valid;
            state_nxt = in_valid ? ST_DATA : ST_IFG;
          end else begin
`ifdef ETH_TX_PAD_EN
            state_nxt = (byte_cnt < 6'(MIN_FRAME_BYTES - 1)) ? ST_PAD : ST_FCS;
`else
            state_nxt = ST_FCS;
`endif
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        tx_en  = 1'b1;
        crc_en = 1'b1;
        if (cnt == 8'd7) begin
          cnt_nxt = '0;
          if (byte_cnt == 6'(MIN_FRAME_BYTES - 1)) state_nxt = ST_FCS;
        end
      end
`endif
      ST_FCS: begin
        tx_en  = 1'b1;
        tx_bit = ~crc[fcs_idx];
        if (cnt == 8'(FCS_BITS - 1)) begin
          cnt_nxt    = '0;
          frame_done = 1'b1;
          state_nxt  = ST_IFG;
        end
      end
      ST_IFG: begin
        // The last gap cycle doubles as the idle decision so back-to-back gaps are exactly IFG_BITS.
        if (cnt == 8'(IFG_BITS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = in_valid ? ST_PREAMBLE : ST_IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        shreg  <= in_data;
        last_q <= in_last;
      end else if (state == ST_DATA) begin
        shreg <= {1'b0, shreg[7:1]};
      end
    end
  end

  eth_fcs u_fcs (
    .clk     (clk),
    .reset_n (reset_n),
    .reset   (crc_rst),
    .en      (crc_en),
    .data_in (tx_bit),
    .crc     (crc)
  );

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: captures the serial line and compares against a byte-wise CRC-32 model.
module tb_eth_tx_framer;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_en;
  logic       frame_done;
  logic       underrun;

  int checks;
  int failures;

  logic [7:0] fb [0:63];
  logic       bits[$];
  logic       exp_bits[$];
  int         pre_gap, done_cnt, done_pos, under_cnt, under_pos, acc_cnt, idle_err;
  logic       timed_out;

  eth_tx_framer #(.IFG_BITS(96)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .tx_bit     (tx_bit),
    .tx_en      (tx_en),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference line image: reflected byte-wise CRC-32, independent of the serial hardware form.
  task automatic build_exp(input int n);
    logic [7:0]  sfd_v;
    logic [7:0]  b;
    logic [31:0] c;
    int total;
    sfd_v = 8'hD5;
    exp_bits.delete();
    for (int i = 0; i < 56; i++) exp_bits.push_back((i % 2) == 0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(sfd_v[i]);
    total = n;
`ifdef ETH_TX_PAD_EN
    if (total < 60) total = 60;
`endif
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < total; i++) begin
      b = (i < n) ? fb[i] : 8'h00;
      for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 32; k++) exp_bits.push_back(c[k]);
  endtask

  task automatic compare_bits(input string tag);
    int mism;
    int lim;
    mism = 0;
    lim = (bits.size() < exp_bits.size()) ? bits.size() : exp_bits.size();
    for (int i = 0; i < lim; i++) if (bits[i] !== exp_bits[i]) mism++;
    check({tag, "_len"}, 32'(bits.size()), 32'(exp_bits.size()));
    check({tag, "_bit_errors"}, 32'(mism), 32'd0);
  endtask

  // Drives one frame through the handshake and records the line until tx_en falls after the frame.
  task automatic run_frame(input int n, input int drop_at, input bit hold_valid);
    int  idx;
    int  cyc;
    bit  prev_acc;
    bit  dropped;
    bit  seen;
    bits.delete();
    pre_gap = 0; done_cnt = 0; done_pos = 0; under_cnt = 0; under_pos = 0; acc_cnt = 0;
    idx = 0; dropped = 0; seen = 0; prev_acc = 0;
    in_valid = 1'b1;
    in_data  = fb[0];
    in_last  = (n == 1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (prev_acc) begin
        idx++;
        acc_cnt++;
      end
      if (idx < n) begin
        in_data = fb[idx];
        in_last = (idx == n - 1);
      end
      in_valid = dropped ? 1'b0 : ((idx < n) ? 1'b1 : hold_valid);
      if (in_ready && idx == drop_at && !dropped) begin
        in_valid = 1'b0;
        dropped  = 1;
      end
      #1;
      prev_acc = in_ready && in_valid;
      if (!tx_en && tx_bit) idle_err++;
      if (tx_en) begin
        seen = 1;
        bits.push_back(tx_bit);
      end else if (seen) begin
        break;
      end else begin
        pre_gap++;
      end
      if (underrun) begin
        under_cnt++;
        under_pos = bits.size();
      end
      if (frame_done) begin
        done_cnt++;
        done_pos = bits.size();
      end
    end
    timed_out = (cyc >= 3000);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
  endtask

  initial begin
    logic [31:0] fcs_word;
    checks = 0; failures = 0; idle_err = 0;
    reset_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs", {27'h0, tx_en, tx_bit, in_ready, frame_done, underrun}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("idle_no_valid", {27'h0, tx_en, tx_bit, in_ready, frame_done, underrun}, 32'h0);

    // "123456789".
    load_digits();
    run_frame(9, -1, 1'b0);
    build_exp(9);
    check("f9_timeout", 32'(timed_out), 32'd0);
    compare_bits("f9");
    check("f9_accepts", 32'(acc_cnt), 32'd9);
    check("f9_done_cnt", 32'(done_cnt), 32'd1);
    check("f9_underrun", 32'(under_cnt), 32'd0);
`ifndef ETH_TX_PAD_EN
    fcs_word = '0;
    for (int k = 0; k < 32; k++) if (136 + k < bits.size()) fcs_word[k] = bits[136 + k];
    check("f9_fcs_bytes", fcs_word, 32'hCBF4_3926);
    check("f9_done_pos", 32'(done_pos), 32'd168);
`else
    check("f9_done_pos", 32'(done_pos), 32'd576);
`endif

    // Single zero byte: padded or not depending on the build.
    fb[0] = 8'h00;
    run_frame(1, -1, 1'b0);
    build_exp(1);
    check("f1_timeout", 32'(timed_out), 32'd0);
    compare_bits("f1");
`ifdef ETH_TX_PAD_EN
    check("f1_tx_en_cycles", 32'(bits.size()), 32'd576);
`else
    check("f1_tx_en_cycles", 32'(bits.size()), 32'd104);
`endif
    check("f1_done_cnt", 32'(done_cnt), 32'd1);

    // Underrun: in_valid withheld on the ready cycle after three bytes.
    load_digits();
    run_frame(9, 3, 1'b0);
    check("ur_timeout", 32'(timed_out), 32'd0);
    check("ur_pulses", 32'(under_cnt), 32'd1);
    check("ur_pulse_bit", 32'(under_pos), 32'd88);
    check("ur_tx_en_bits", 32'(bits.size()), 32'd88);
    check("ur_done_cnt", 32'(done_cnt), 32'd0);
    run_frame(9, -1, 1'b0);
    build_exp(9);
    check("ur_ifg_len", 32'(pre_gap + 1), 32'd96);
    compare_bits("after_ur");

    // Back-to-back frames with in_valid held high.
    fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'hFF; fb[3] = 8'h00; fb[4] = 8'h81;
    run_frame(5, -1, 1'b1);
    build_exp(5);
    compare_bits("b2b_a");
    fb[0] = 8'h5A; fb[1] = 8'h01; fb[2] = 8'h80;
    run_frame(3, -1, 1'b0);
    build_exp(3);
    check("b2b_gap", 32'(pre_gap + 1), 32'd96);
    compare_bits("b2b_b");
    check("b2b_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of DATA.
    fb[0] = 8'h77;
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    check("pre_reset_tx_en", 32'(tx_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'h0, tx_en, tx_bit, in_ready, frame_done, underrun}, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    load_digits();
    run_frame(9, -1, 1'b0);
    build_exp(9);
    check("post_reset_gap", 32'(pre_gap), 32'd0);
    compare_bits("post_reset");
    check("post_reset_done", 32'(done_cnt), 32'd1);

    check("idle_line_quiet", 32'(idle_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
